nubus_arb_master_ctrl: RTL

- Parametrised, clocked successor to the combinational NuBus arbiter/direction glue.
- Sequences one bus tenure: request, distributed ARB_W-bit arbitration, wait for bus idle, direction turnaround, ownership, release.
- Enforces NuBus fairness: after losing, do not re-request until RQST* goes idle.
- Sits between the FPGA master engine and the 5V open-drain transceivers; drives the same master_dir and driver-disable controls the glue consumes.

---
 rtl/nubus_arb_master_ctrl.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/nubus_arb_master_ctrl.sv
// NuBus bus-tenure sequencer for the FPGA master engine.
// Runs request, distributed ARB_W-bit arbitration, wait for bus idle,
// direction turnaround, ownership and release. It also enforces the NuBus
// fairness rule: after a loss, the card stays off RQST* until the line goes idle.
// The outputs drive the open-drain ARB*/RQST* pull-downs and the transceiver
// direction and disable controls.

module nubus_arb_master_ctrl #(
  parameter int ARB_W         = 4,
  parameter int SETTLE_CYCLES = 5,
  parameter int TURN_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ARB_W-1:0] id_n,
  input  logic [ARB_W-1:0] arb_n_i,
  output logic [ARB_W-1:0] arb_n_oe,
  input  logic             rqst_n_i,
  output logic             rqst_oe,
  input  logic             start_n_i,
  input  logic             ack_n_i,
  input  logic             req,
  input  logic             done,
  output logic             grant,
  output logic             lost,
  output logic             master_dir,
  output logic             drv_dis
);

  localparam int ACW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TCW = $clog2(TURN_CYCLES + 1);

  // Arbitration sample point, last turnaround step, and the extra TURN_OUT step
  // that holds drv_dis=1 while master_dir settles low.
  localparam logic [ACW-1:0] ARB_LAST  = ACW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CYCLES - 1);
  localparam logic [TCW-1:0] TURN_END  = TCW'(TURN_CYCLES);
  localparam logic [ACW-1:0] ARB_ONE   = ACW'(1);
  localparam logic [TCW-1:0] TURN_ONE  = TCW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARB      = 3'd1,
    S_WAIT_BUS = 3'd2,
    S_TURN_IN  = 3'd3,
    S_OWN      = 3'd4,
    S_TURN_OUT = 3'd5,
    S_BACKOFF  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [ACW-1:0]   arb_cnt_q, arb_cnt_d;
  logic [TCW-1:0]   turn_cnt_q, turn_cnt_d;
  logic             busy_q, busy_d;
  logic             done_lat_q, done_lat_d;
  logic [ARB_W-1:0] arb_n_oe_q, arb_n_oe_d;
  logic             rqst_oe_q, rqst_oe_d;
  logic             grant_q, grant_d;
  logic             lost_q, lost_d;
  logic             master_dir_q, master_dir_d;
  logic             drv_dis_q, drv_dis_d;
  logic [ARB_W-1:0] arb_term;

  // Pull ARB line k only if our ID bit k is 1 and every higher line already
  // matches our ID. A higher-priority competitor therefore knocks out our
  // lower bits.
  function automatic logic [ARB_W-1:0] arb_drive(input logic [ARB_W-1:0] id_l,
                                                 input logic [ARB_W-1:0] bus_l);
    logic [ARB_W-1:0] drv;
    logic             above_ok;
    drv = '0;
    for (int k = 0; k < ARB_W; k++) begin
      above_ok = 1'b1;
      for (int j = k + 1; j < ARB_W; j++) begin
        above_ok = above_ok & (bus_l[j] == id_l[j]);
      end
      drv[k] = ~id_l[k] & above_ok;
    end
    return drv;
  endfunction

  // Arbitration drive term from the currently sampled ARB* lines.
  always_comb begin
    arb_term = arb_drive(id_n, arb_n_i);
  end

  // Bus-busy tracking: START sets the flag, an ACK without START clears it.
  always_comb begin
    busy_d = busy_q;
    if (!start_n_i) begin
      busy_d = 1'b1;
    end else if (!ack_n_i) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // Next-state and next-output logic for the tenure sequencer.
  always_comb begin
    state_d      = state_q;
    arb_cnt_d    = arb_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    done_lat_d   = done_lat_q;
    arb_n_oe_d   = arb_n_oe_q;
    rqst_oe_d    = rqst_oe_q;
    grant_d      = grant_q;
    lost_d       = 1'b0;
    master_dir_d = master_dir_q;
    drv_dis_d    = drv_dis_q;

    case (state_q)
      S_IDLE: begin
        arb_n_oe_d   = '0;
        grant_d      = 1'b0;
        master_dir_d = 1'b0;
        drv_dis_d    = 1'b0;
        done_lat_d   = 1'b0;
        arb_cnt_d    = '0;
        if (req) begin
          state_d   = S_ARB;
          rqst_oe_d = 1'b1;
        end else begin
          rqst_oe_d = 1'b0;
        end
      end

      S_ARB: begin
        rqst_oe_d = 1'b1;
        if (!req) begin
          // The engine abandoned the request, so withdraw quietly with no lost pulse.
          state_d    = S_IDLE;
          rqst_oe_d  = 1'b0;
          arb_n_oe_d = '0;
        end else if (arb_cnt_q == ARB_LAST) begin
          if (arb_n_i == id_n) begin
            state_d    = S_WAIT_BUS;
            arb_n_oe_d = arb_term;
          end else begin
            state_d    = S_BACKOFF;
            lost_d     = 1'b1;
            arb_n_oe_d = '0;
            rqst_oe_d  = 1'b0;
          end
        end else begin
          arb_n_oe_d = arb_term;
          arb_cnt_d  = arb_cnt_q + ARB_ONE;
        end
      end

      S_WAIT_BUS: begin
        // This uses the busy value that includes this cycle's START/ACK sample,
        // so an ACK ends the wait immediately.
        if (!busy_d && start_n_i) begin
          state_d      = S_TURN_IN;
          drv_dis_d    = 1'b1;
          master_dir_d = 1'b1;
          turn_cnt_d   = '0;
          done_lat_d   = 1'b0;
        end else begin
          state_d = S_WAIT_BUS;
        end
      end

      S_TURN_IN: begin
        if (done) begin
          done_lat_d = 1'b1;
        end else begin
          done_lat_d = done_lat_q;
        end
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = S_OWN;
          drv_dis_d  = 1'b0;
          grant_d    = 1'b1;
          arb_n_oe_d = '0;
          rqst_oe_d  = 1'b0;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_ONE;
        end
      end

      S_OWN: begin
        grant_d      = 1'b1;
        master_dir_d = 1'b1;
        drv_dis_d    = 1'b0;
        if (done || done_lat_q) begin
          state_d    = S_TURN_OUT;
          grant_d    = 1'b0;
          drv_dis_d  = 1'b1;
          turn_cnt_d = '0;
          done_lat_d = 1'b0;
        end else begin
          state_d = S_OWN;
        end
      end

      S_TURN_OUT: begin
        // Drivers stay off across the direction flip and for one cycle after it.
        drv_dis_d = 1'b1;
        if (turn_cnt_q == TURN_END) begin
          state_d   = S_IDLE;
          drv_dis_d = 1'b0;
        end else if (turn_cnt_q == TURN_LAST) begin
          master_dir_d = 1'b0;
          turn_cnt_d   = TURN_END;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_ONE;
        end
      end

      S_BACKOFF: begin
        arb_n_oe_d   = '0;
        rqst_oe_d    = 1'b0;
        grant_d      = 1'b0;
        master_dir_d = 1'b0;
        drv_dis_d    = 1'b0;
        if (rqst_n_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BACKOFF;
        end
      end

      default: begin
        state_d      = S_IDLE;
        arb_n_oe_d   = '0;
        rqst_oe_d    = 1'b0;
        grant_d      = 1'b0;
        master_dir_d = 1'b0;
        drv_dis_d    = 1'b1;
        arb_cnt_d    = '0;
        turn_cnt_d   = '0;
        done_lat_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      arb_cnt_q    <= '0;
      turn_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_lat_q   <= 1'b0;
      arb_n_oe_q   <= '0;
      rqst_oe_q    <= 1'b0;
      grant_q      <= 1'b0;
      lost_q       <= 1'b0;
      master_dir_q <= 1'b0;
      drv_dis_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      arb_cnt_q    <= arb_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      busy_q       <= busy_d;
      done_lat_q   <= done_lat_d;
      arb_n_oe_q   <= arb_n_oe_d;
      rqst_oe_q    <= rqst_oe_d;
      grant_q      <= grant_d;
      lost_q       <= lost_d;
      master_dir_q <= master_dir_d;
      drv_dis_q    <= drv_dis_d;
    end
  end

  assign arb_n_oe   = arb_n_oe_q;
  assign rqst_oe    = rqst_oe_q;
  assign grant      = grant_q;
  assign lost       = lost_q;
  assign master_dir = master_dir_q;
  assign drv_dis    = drv_dis_q;

endmodule
